// File: rtl/sr_cpu_mc_if.sv
// Instruction-memory fetch port: the core holds imReq/imAddr until memory answers with imAck/imData.
// Memory may take any number of cycles to acknowledge; the core waits without timing out.
interface sr_cpu_mc_if #(
  parameter int IM_AW = 30
);
  logic             imReq;
  logic [IM_AW-1:0] imAddr;
  logic             imAck;
  logic [31:0]      imData;

  modport master (output imReq, output imAddr, input imAck, input imData);
  modport slave  (input imReq, input imAddr, output imAck, output imData);
endinterface

// File: rtl/sr_cpu_mc.sv
// Multi-cycle schoolRISCV core: BOOT -> (FETCH -> EXEC)*, illegal encodings park it in TRAP.
// Two cycles per instruction minimum; each cycle the fetch port waits for imAck adds one.
module sr_cpu_mc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32,
  parameter int          IM_AW     = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   regAddr,
  output logic [31:0]  regData,
  sr_cpu_mc_if.master  im,
  output logic         retired,
  output logic [31:0]  instret,
  output logic         trap
);

  localparam int RAW = $clog2(REG_COUNT);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_t;

  state_t      state, stateNext;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rf [REG_COUNT];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] immI, immB, immJ;
  logic [31:0] rs1Val, rs2Val, diff;
  logic [31:0] pcPlus4, jalTarget;
  logic [31:0] wrData, pcNext;
  logic        wrEn, legalOp, legal;
  logic        useRs1, useRs2, useRd;
  logic        fetchReq;

  function automatic logic regOk(input logic [4:0] idx);
    return int'(idx) < REG_COUNT;
  endfunction

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign immI = {{20{ir[31]}}, ir[31:20]};
  assign immB = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign immJ = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  // x0 is never written, so its storage slot is simply ignored on read
  assign rs1Val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RAW-1:0]];
  assign rs2Val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RAW-1:0]];
  assign diff   = rs1Val - rs2Val;

  assign pcPlus4   = pc + 32'd4;
  assign jalTarget = pc + immJ;

  always_comb begin
    legalOp = 1'b0;
    wrEn    = 1'b0;
    wrData  = 32'd0;
    pcNext  = pcPlus4;
    useRs1  = 1'b0;
    useRs2  = 1'b0;
    useRd   = 1'b0;
    case (opcode)
      OP_R: begin
        useRs1  = 1'b1;
        useRs2  = 1'b1;
        useRd   = 1'b1;
        legalOp = 1'b1;
        wrEn    = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'h0}: wrData = rs1Val + rs2Val;
          {7'h20, 3'h0}: wrData = diff;
          {7'h00, 3'h7}: wrData = rs1Val & rs2Val;
          {7'h00, 3'h6}: wrData = rs1Val | rs2Val;
          {7'h00, 3'h5}: wrData = rs1Val >> rs2Val[4:0];
          {7'h00, 3'h2}: wrData = {31'd0, $signed(rs1Val) < $signed(rs2Val)};
          {7'h00, 3'h3}: wrData = {31'd0, rs1Val < rs2Val};
          default: begin
            legalOp = 1'b0;
            wrEn    = 1'b0;
          end
        endcase
      end
      OP_I: begin
        useRs1 = 1'b1;
        useRd  = 1'b1;
        case (funct3)
          3'h0: begin
            legalOp = 1'b1;
            wrEn    = 1'b1;
            wrData  = rs1Val + immI;
          end
          3'h7: begin
            legalOp = 1'b1;
            wrEn    = 1'b1;
            wrData  = rs1Val & immI;
          end
          default: ;
        endcase
      end
      OP_LUI: begin
        useRd   = 1'b1;
        legalOp = 1'b1;
        wrEn    = 1'b1;
        wrData  = {ir[31:12], 12'd0};
      end
      OP_B: begin
        useRs1 = 1'b1;
        useRs2 = 1'b1;
        case (funct3)
          3'h0: begin
            legalOp = 1'b1;
            if (diff == 32'd0) pcNext = pc + immB;
          end
          3'h1: begin
            legalOp = 1'b1;
            if (diff != 32'd0) pcNext = pc + immB;
          end
          default: ;
        endcase
      end
      OP_JAL: begin
        useRd   = 1'b1;
        legalOp = !jalTarget[1];
        wrEn    = 1'b1;
        wrData  = pcPlus4;
        pcNext  = jalTarget;
      end
      default: ;
    endcase
    // RV32E-style builds reject any register index beyond the implemented file
    legal = legalOp
         && (!useRs1 || regOk(rs1))
         && (!useRs2 || regOk(rs2))
         && (!useRd  || regOk(rd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    fetchReq  = 1'b0;
    case (state)
      BOOT:  stateNext = FETCH;
      FETCH: begin
        fetchReq = 1'b1;
        if (im.imAck) stateNext = EXEC;
      end
      EXEC:  stateNext = legal ? FETCH : TRAP;
      TRAP:  stateNext = TRAP;
      default: stateNext = BOOT;
    endcase
  end

  assign im.imReq  = fetchReq;
  assign im.imAddr = pc[IM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      instret <= 32'd0;
      trap    <= 1'b0;
      retired <= 1'b0;
    end else begin
      retired <= 1'b0;
      if (state == FETCH && im.imAck) ir <= im.imData;
      if (state == EXEC) begin
        if (legal) begin
          pc      <= pcNext;
          instret <= instret + 32'd1;
          retired <= 1'b1;
        end else begin
          trap <= 1'b1;
        end
      end
    end
  end

  // Register contents survive reset by design
  always_ff @(posedge clk) begin
    if (state == EXEC && legal && wrEn && rd != 5'd0)
      rf[rd[RAW-1:0]] <= wrData;
  end

  always_comb begin
    regData = 32'd0;
    if (regAddr == 5'd0)    regData = pc;
    else if (regOk(regAddr)) regData = rf[regAddr[RAW-1:0]];
  end

endmodule

// File: tb/tb_sr_cpu_mc.sv
// Directed bench: a 32-register core with a wait-stateable memory and a 16-register core at 0x80.
module tb_sr_cpu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  regAddrA = 5'd0;
  logic [4:0]  regAddrB = 5'd0;
  logic [31:0] regDataA, regDataB;
  logic        retiredA, retiredB, trapA, trapB;
  logic [31:0] instretA, instretB;
  int          ackDelay = 0;
  int          waitCnt;
  int          passes = 0;
  int          total = 0;
  logic [31:0] memA [64];
  logic [31:0] memB [64];

  always #5 clk = ~clk;

  sr_cpu_mc_if #(.IM_AW(30)) ifA ();
  sr_cpu_mc_if #(.IM_AW(30)) ifB ();

  sr_cpu_mc #(.RESET_PC(32'h0), .REG_COUNT(32), .IM_AW(30)) dutA (
    .clk(clk), .rst(rst), .regAddr(regAddrA), .regData(regDataA), .im(ifA),
    .retired(retiredA), .instret(instretA), .trap(trapA)
  );

  sr_cpu_mc #(.RESET_PC(32'h80), .REG_COUNT(16), .IM_AW(30)) dutB (
    .clk(clk), .rst(rst), .regAddr(regAddrB), .regData(regDataB), .im(ifB),
    .retired(retiredB), .instret(instretB), .trap(trapB)
  );

  // Memory A acknowledges after ackDelay wait cycles; memory B always answers at once
  always @(posedge clk or posedge rst) begin
    if (rst)                            waitCnt <= 0;
    else if (ifA.imReq && !ifA.imAck)   waitCnt <= waitCnt + 1;
    else                                waitCnt <= 0;
  end
  assign ifA.imAck  = (waitCnt >= ackDelay);
  assign ifA.imData = memA[ifA.imAddr[5:0]];
  assign ifB.imAck  = 1'b1;
  assign ifB.imData = memB[ifB.imAddr[5:0]];

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] s2,
                                       input logic [4:0] s1, input logic [2:0] f3,
                                       input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction
  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] s1,
                                       input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'h13};
  endfunction
  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] s2,
                                       input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'h6F};
  endfunction
  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] d);
    return {imm, d, 7'h37};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chkRegA(input string tag, input logic [4:0] a, input logic [31:0] exp);
    regAddrA = a;
    @(negedge clk);
    chk(tag, regDataA, exp);
    regAddrA = 5'd0;
  endtask

  task automatic chkRegB(input string tag, input logic [4:0] a, input logic [31:0] exp);
    regAddrB = a;
    @(negedge clk);
    chk(tag, regDataB, exp);
    regAddrB = 5'd0;
  endtask

  // Asserts reset wherever the core is, checks the async clear, releases into BOOT
  task automatic doReset();
    rst = 1'b1;
    #1;
    chk("rst_imReq",   {31'd0, ifA.imReq}, 32'd0);
    chk("rst_pc",      regDataA, 32'h0);
    chk("rst_instret", instretA, 32'd0);
    chk("rst_trap",    {31'd0, trapA}, 32'd0);
    chk("rst_retired", {31'd0, retiredA}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic loadProg1();
    for (int i = 0; i < 64; i++) memA[i] = 32'd0;
    memA[0] = 32'h0050_0093;  // addi x1,x0,5
    memA[1] = 32'hFFD0_0113;  // addi x2,x0,-3
    memA[2] = 32'h0020_81B3;  // add  x3,x1,x2
  endtask

  initial begin
    // Phase 1: zero-wait memory, three-instruction program; core B traps on x17
    loadProg1();
    for (int i = 0; i < 64; i++) memB[i] = 32'd0;
    memB[32] = 32'h0030_0093;  // addi x1,x0,3
    memB[33] = 32'h0010_0893;  // addi x17,x0,1
    doReset();
    chk("boot_pcB", regDataB, 32'h80);
    step(1);
    chk("e1_imReq",  {31'd0, ifA.imReq}, 32'd1);
    chk("e1_imAddr", {2'd0, ifA.imAddr}, 32'd0);
    chk("e1_imAddrB", {2'd0, ifB.imAddr}, 32'h20);
    step(2);
    chk("e3_instret", instretA, 32'd1);
    chk("e3_retired", {31'd0, retiredA}, 32'd1);
    chk("e3_pcB", regDataB, 32'h84);
    step(2);
    chk("e5_instret", instretA, 32'd2);
    chk("e5_trapB", {31'd0, trapB}, 32'd1);
    chk("e5_pcB", regDataB, 32'h84);
    chk("e5_instretB", instretB, 32'd1);
    chk("e5_imReqB", {31'd0, ifB.imReq}, 32'd0);
    step(1);
    chk("e6_instret", instretA, 32'd2);
    step(1);
    chk("e7_instret", instretA, 32'd3);
    chk("e7_pc", regDataA, 32'd12);
    step(2);
    chk("p1_trapOnZero", {31'd0, trapA}, 32'd1);
    chk("p1_instretHeld", instretA, 32'd3);
    chkRegA("p1_x1", 5'd1, 32'd5);
    chkRegA("p1_x2", 5'd2, 32'hFFFF_FFFD);
    chkRegA("p1_x3", 5'd3, 32'd2);
    chkRegB("B_x1", 5'd1, 32'd3);
    chkRegB("B_x17", 5'd17, 32'd0);

    // Phase 2: same program, three wait states per fetch
    ackDelay = 3;
    doReset();
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("p2_waitReq",  {31'd0, ifA.imReq}, 32'd1);
      chk("p2_waitAddr", {2'd0, ifA.imAddr}, 32'd0);
    end
    step(11);
    chk("p2_e15_instret", instretA, 32'd2);
    step(1);
    chk("p2_e16_instret", instretA, 32'd3);
    chkRegA("p2_x3", 5'd3, 32'd2);

    // Phase 3: branches, compares, logic ops, JAL, LUI, x0 write, misaligned JAL
    ackDelay = 0;
    for (int i = 0; i < 64; i++) memA[i] = 32'd0;
    memA[0]  = encI(12'd7, 5'd0, 3'd0, 5'd1);
    memA[1]  = encI(12'd7, 5'd0, 3'd0, 5'd2);
    memA[2]  = encB(13'd8, 5'd2, 5'd1, 3'd0);
    memA[3]  = encI(12'd1, 5'd0, 3'd0, 5'd6);
    memA[4]  = encB(13'd8, 5'd2, 5'd1, 3'd1);
    memA[5]  = encI(12'hFFF, 5'd0, 3'd0, 5'd7);
    memA[6]  = encR(7'h00, 5'd1, 5'd7, 3'd2, 5'd4);
    memA[7]  = encR(7'h00, 5'd1, 5'd7, 3'd3, 5'd8);
    memA[8]  = encR(7'h00, 5'd7, 5'd1, 3'd7, 5'd9);
    memA[9]  = encR(7'h20, 5'd7, 5'd1, 3'd0, 5'd10);
    memA[10] = encR(7'h00, 5'd1, 5'd7, 3'd5, 5'd11);
    memA[11] = encJ(21'd20, 5'd0);
    memA[12] = encJ(21'd24, 5'd0);
    memA[16] = encJ(21'h1F_FFF0, 5'd5);
    memA[18] = encU(20'h12345, 5'd12);
    memA[19] = encI(12'h0F0, 5'd7, 3'd7, 5'd13);
    memA[20] = encI(12'd9, 5'd0, 3'd0, 5'd0);
    memA[21] = encR(7'h00, 5'd10, 5'd1, 3'd6, 5'd14);
    memA[22] = encJ(21'd2, 5'd0);
    doReset();
    step(7);
    chk("beq_taken_pc", regDataA, 32'd16);
    step(2);
    chk("bne_fall_pc", regDataA, 32'd20);
    step(16);
    chk("jal_back_pc", regDataA, 32'h30);
    step(8);
    chk("x0w_retired", {31'd0, retiredA}, 32'd1);
    chk("x0w_instret", instretA, 32'd16);
    step(1);
    chk("retired_1cyc", {31'd0, retiredA}, 32'd0);
    step(1);
    chk("p3_instret", instretA, 32'd17);
    chk("p3_pc", regDataA, 32'd88);
    step(2);
    chk("jal2_trap",    {31'd0, trapA}, 32'd1);
    chk("jal2_pc",      regDataA, 32'd88);
    chk("jal2_instret", instretA, 32'd17);
    step(4);
    chk("trap_imReq", {31'd0, ifA.imReq}, 32'd0);
    chk("trap_sticky", {31'd0, trapA}, 32'd1);
    chkRegA("slt_x4",  5'd4,  32'd1);
    chkRegA("sltu_x8", 5'd8,  32'd0);
    chkRegA("and_x9",  5'd9,  32'd7);
    chkRegA("sub_x10", 5'd10, 32'd8);
    chkRegA("srl_x11", 5'd11, 32'h01FF_FFFF);
    chkRegA("jal_x5",  5'd5,  32'h44);
    chkRegA("lui_x12", 5'd12, 32'h1234_5000);
    chkRegA("andi_x13", 5'd13, 32'hF0);
    chkRegA("or_x14",  5'd14, 32'hF);
    chkRegA("x0_zero", 5'd0,  32'd88);
    regAddrA = 5'd0;

    // Phase 4: misaligned JAL sitting at 0x40
    for (int i = 0; i < 64; i++) memA[i] = 32'd0;
    memA[0]  = encJ(21'd64, 5'd0);
    memA[16] = encJ(21'd2, 5'd0);
    doReset();
    step(5);
    chk("p4_trap",    {31'd0, trapA}, 32'd1);
    chk("p4_pc",      regDataA, 32'h40);
    chk("p4_instret", instretA, 32'd1);
    step(4);
    chk("p4_imReq", {31'd0, ifA.imReq}, 32'd0);
    chk("p4_pcHeld", regDataA, 32'h40);

    // Phase 5: reset while a fetch is stalled, then a clean restart
    loadProg1();
    doReset();
    step(4);
    ackDelay = 100;
    step(2);
    chk("p5_stallReq",  {31'd0, ifA.imReq}, 32'd1);
    chk("p5_stallAddr", {2'd0, ifA.imAddr}, 32'd2);
    chk("p5_instret",   instretA, 32'd2);
    ackDelay = 0;
    doReset();
    chk("p5_bootReq", {31'd0, ifA.imReq}, 32'd0);
    step(1);
    chk("p5_fetchReq", {31'd0, ifA.imReq}, 32'd1);
    step(6);
    chk("p5_instret3", instretA, 32'd3);
    chkRegA("p5_x3", 5'd3, 32'd2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/sr_cpu_mc.md
Name: sr_cpu_mc

Overview:
- Multi-cycle successor to the single-cycle schoolRISCV core.
- Fetches over a request/acknowledge instruction-memory handshake, so it tolerates wait-stated memory.
- Executes each instruction in a dedicated cycle; parametrised reset vector and register count (RV32I or RV32E-style).
- Adds JAL, SLT and AND, a retired-instruction counter, and a sticky trap on illegal encodings. Sits at the top level in place of the single-cycle core.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch; low 2 bits must be 0.
- REG_COUNT, 32, architectural registers; legal values 32 or 16.
- IM_AW, 30, width of the instruction-memory word address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- regAddr  in  5  debug register address.
- regData  out  32  debug data: pc when regAddr==0, else register value (0 if regAddr>=REG_COUNT).
- imReq  out  1  instruction fetch request.
- imAddr  out  IM_AW  instruction word address = pc[IM_AW+1:2].
- imAck  in  1  fetch data valid this cycle.
- imData  in  32  instruction word, sampled when imReq&&imAck.
- retired  out  1  one-cycle pulse per retired instruction.
- instret  out  32  retired-instruction count.
- trap  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset (async, any state): state=BOOT, pc=RESET_PC, IR=0, instret=0, trap=0, retired=0, imReq=0. Register contents are not reset.
- FSM states: BOOT, FETCH, EXEC, TRAP.
- BOOT: imReq=0; -> FETCH next cycle.
- FETCH: imReq=1; imAddr stable while waiting. On imAck: IR<=imData, -> EXEC. Otherwise stay; no timeout.
- EXEC: imReq=0. Decode IR, run the ALU, and on one clock edge:
  - write rd if enabled (rd==0 discarded);
  - update pc;
  - pulse retired, instret<=instret+1 (wraps 2^32-1 -> 0);
  - -> FETCH.
- EXEC, illegal instruction: no register write, pc unchanged, instret unchanged, trap<=1, -> TRAP.
- TRAP: absorbing; imReq=0, trap=1; only rst exits.
- Throughput: minimum 2 cycles per instruction (imAck in the first FETCH cycle). Each FETCH wait cycle adds one.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, SRL, SLT, SLTU.
  - I-type: ADDI, ANDI.
  - U-type: LUI.
  - B-type: BEQ, BNE.
  - J-type: JAL.
- Illegal: every other encoding, including any rs1/rs2/rd index >= REG_COUNT among fields the instruction uses.
- ALU: 32-bit, two's-complement wrap on ADD/SUB. SRL uses srcB[4:0]. SLT is signed compare; SLTU is unsigned; result is 1 or 0.
- Branch: taken when (rs1-rs2)==0 for BEQ, !=0 for BNE. Target = pc + immB (B-immediate sign-extended, bit0=0). Not taken: pc+4.
- JAL: rd<=pc+4; pc<=pc+immJ (sign-extended, bit0=0). Misaligned target (bit1=1) is illegal -> TRAP.
- LUI: rd<={imm[31:12],12'b0}.
- Register file: read combinationally from IR fields during EXEC, written at the end of EXEC. A register read in EXEC never observes the same instruction's write. x0 always reads 0.
- regData is combinational and valid in every state.

Test Plan:
- Release rst; imAck tied 1 -> BOOT for 1 cycle, first imReq with imAddr=RESET_PC>>2. Program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> x3=2, instret=3 after 6 cycles post-BOOT.
- Same program with imAck delayed 3 cycles per fetch -> imAddr held during waits, identical results, instret=3 after 15 cycles.
- x1=7, x2=7: BEQ x1,x2,+8 -> pc advances by 8. BNE x1,x2,+8 -> pc+4. SLT x4,x2n,x1 with x2n=-1 -> x4=1; SLTU x4,x2n,x1 -> x4=0.
- JAL x5,-16 at pc=0x40 -> x5=0x44, pc=0x30. JAL to offset +2 -> trap=1, pc stays 0x40, imReq stays 0 thereafter.
- REG_COUNT=16: ADDI x17,x0,1 -> trap=1, no write. ADDI x0,x0,9 (any count) -> x0 reads 0, retired pulses.
- Assert rst mid-FETCH (imReq=1, imAck=0) -> imReq drops immediately, pc=RESET_PC, instret=0, trap=0, restart via BOOT.
